// File: rtl/iq_deinterleave.sv
`default_nettype none
// ============================================================================
// Module      : iq_deinterleave
// Description : Splits an interleaved little-endian byte stream (I_lo, I_hi,
//               Q_lo, Q_hi) into sign-extended, left-shifted I and Q sample
//               words, written in lock-step to two sample FIFOs.
//               Optional build macro IQ_DEINT_COUNT_EN adds a 32-bit
//               sample_count output counting written I/Q pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_deinterleave #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [7:0]           in_dout,
    input  logic                 i_out_full,
    output logic                 i_out_wr_en,
    output logic [DATA_SIZE-1:0] i_out_din,
    input  logic                 q_out_full,
    output logic                 q_out_wr_en,
    output logic [DATA_SIZE-1:0] q_out_din
`ifdef IQ_DEINT_COUNT_EN
    ,
    output logic [31:0]          sample_count
`endif
);

    generate
        if (DATA_SIZE < 16 + BITS) begin : g_cfg_check
            $error("iq_deinterleave: DATA_SIZE must be at least 16+BITS");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               state_q;
    logic [1:0]           byte_cnt_q;
    logic [7:0]           b0_q;
    logic [7:0]           b1_q;
    logic [7:0]           b2_q;
    logic [DATA_SIZE-1:0] i_din_q;
    logic [DATA_SIZE-1:0] q_din_q;

    logic                 w_pop;
    logic                 w_push;
    logic [15:0]          w_i16;
    logic [15:0]          w_q16;
    logic [DATA_SIZE-1:0] w_i_ext;
    logic [DATA_SIZE-1:0] w_q_ext;

    // Pop is gated by reset so the upstream FIFO is never drained while held.
    assign w_pop  = reset && (state_q == S_READ) && !in_empty;
    assign w_push = (state_q == S_WRITE) && !i_out_full && !q_out_full;

    // Q_hi is taken straight from the FIFO head on the cycle it is popped.
    assign w_i16   = {b1_q, b0_q};
    assign w_q16   = {in_dout, b2_q};
    assign w_i_ext = {{(DATA_SIZE-16){w_i16[15]}}, w_i16};
    assign w_q_ext = {{(DATA_SIZE-16){w_q16[15]}}, w_q16};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_READ;
            byte_cnt_q <= 2'd0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            b2_q       <= 8'd0;
            i_din_q    <= '0;
            q_din_q    <= '0;
        end else begin
            case (state_q)
                S_READ: begin
                    if (w_pop) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: b0_q <= in_dout;
                            2'd1: b1_q <= in_dout;
                            2'd2: b2_q <= in_dout;
                            default: begin
                                i_din_q <= w_i_ext << BITS;
                                q_din_q <= w_q_ext << BITS;
                                state_q <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (w_push) begin
                        state_q <= S_READ;
                    end
                end
            endcase
        end
    end

    assign in_rd_en    = w_pop;
    assign i_out_wr_en = w_push;
    assign q_out_wr_en = w_push;
    assign i_out_din   = i_din_q;
    assign q_out_din   = q_din_q;

`ifdef IQ_DEINT_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'd0;
        end else if (w_push) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign sample_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_deinterleave.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_deinterleave
// Description : Self-checking bench for iq_deinterleave; a byte-queue model
//               predicts pops, paired writes and sample values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_deinterleave;

    localparam int DATA_SIZE = 32;
    localparam int BITS      = 10;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 in_empty = 1'b1;
    logic [7:0]           in_dout  = 8'd0;
    logic                 i_full   = 1'b0;
    logic                 q_full   = 1'b0;
    logic                 in_rd_en;
    logic                 i_wr;
    logic                 q_wr;
    logic [DATA_SIZE-1:0] i_din;
    logic [DATA_SIZE-1:0] q_din;
`ifdef IQ_DEINT_COUNT_EN
    logic [31:0]          sample_count;
`endif

    iq_deinterleave #(.DATA_SIZE(DATA_SIZE), .BITS(BITS)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .in_dout     (in_dout),
        .i_out_full  (i_full),
        .i_out_wr_en (i_wr),
        .i_out_din   (i_din),
        .q_out_full  (q_full),
        .q_out_wr_en (q_wr),
        .q_out_din   (q_din)
`ifdef IQ_DEINT_COUNT_EN
        ,
        .sample_count(sample_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sign-extend the 16-bit sample and multiply by 2**BITS.
    function automatic logic [31:0] quant(input logic [15:0] x);
        longint v;
        v = longint'(signed'(x));
        v = v * (longint'(1) << BITS);
        return v[31:0];
    endfunction

    // Behavioural model state
    logic [7:0]  grp[$];
    bit          pending     = 1'b0;
    logic [31:0] exp_i       = 32'd0;
    logic [31:0] exp_q       = 32'd0;
    int          writes      = 0;
    logic [31:0] model_count = 32'd0;
    bit          m_wr;
    bit          m_pop;
    bit          chk_period  = 1'b0;
    int          prev_wr_cyc = -1;
    int          cyc         = 0;
    bit          rnd_full    = 1'b0;
    int          exp_writes  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rd_en", in_rd_en, 1'b0);
            check("rst_i_wr", i_wr, 1'b0);
            check("rst_q_wr", q_wr, 1'b0);
            check("rst_i_din", i_din, 32'd0);
            check("rst_q_din", q_din, 32'd0);
            grp.delete();
            pending     = 1'b0;
            exp_i       = 32'd0;
            exp_q       = 32'd0;
            model_count = 32'd0;
            prev_wr_cyc = -1;
        end else begin
            m_wr  = pending && !i_full && !q_full;
            m_pop = !in_empty && !pending;
            check("rd_en", in_rd_en, m_pop);
            check("i_wr_en", i_wr, m_wr);
            check("q_wr_en", q_wr, m_wr);
            check("i_din", i_din, exp_i);
            check("q_din", q_din, exp_q);
`ifdef IQ_DEINT_COUNT_EN
            check("sample_count", sample_count, model_count);
`endif
            if (m_wr) begin
                if (chk_period && prev_wr_cyc >= 0)
                    check("write_period", 64'(cyc - prev_wr_cyc), 64'd5);
                prev_wr_cyc = cyc;
                pending     = 1'b0;
                writes++;
                model_count = model_count + 32'd1;
            end
            if (m_pop) begin
                grp.push_back(in_dout);
                if (grp.size() == 4) begin
                    exp_i   = quant({grp[1], grp[0]});
                    exp_q   = quant({grp[3], grp[2]});
                    grp.delete();
                    pending = 1'b1;
                end
            end
        end
    end

    // Present one byte and hold it until the DUT pops it.
    task automatic feed(input logic [7:0] b, input int gap);
        bit popped;
        popped   = 1'b0;
        in_empty = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_empty = 1'b0;
        in_dout  = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_rd_en) begin
                popped = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd_full) begin
                i_full = ($urandom_range(3) == 0);
                q_full = ($urandom_range(3) == 0);
            end
        end
        if (!popped) check("feed_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_empty = 1'b1;
    endtask

    task automatic feed_group(input logic [31:0] w, input int gap);
        for (int j = 0; j < 4; j++) feed(w[8*j +: 8], gap);
        exp_writes++;
    endtask

    int wr_before;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_en", in_rd_en, 1'b0);
        check("reset_i_din", i_din, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nominal group: write one cycle after the 4th pop.
        feed_group(32'hABCD1234, 0);
        @(negedge clk);
        check("nominal_latency", i_wr, 1'b1);
        check("nominal_i", i_din, 32'h0048D000);
        check("nominal_q", q_din, 32'hFEAF3400);
        @(posedge clk); #1;

        // Extreme values.
        feed_group(32'h7FFF8000, 0);
        @(negedge clk);
        check("extreme_wr", q_wr, 1'b1);
        check("extreme_i", i_din, 32'hFE000000);
        check("extreme_q", q_din, 32'h01FFFC00);
        @(posedge clk); #1;

        // Backpressure on I, then on Q only.
        for (int side = 0; side < 2; side++) begin
            wr_before = writes;
            if (side == 0) i_full = 1'b1; else q_full = 1'b1;
            feed_group($urandom, 0);
            in_empty = 1'b0;
            in_dout  = 8'h5A;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("bp_no_i_wr", i_wr, 1'b0);
                check("bp_no_q_wr", q_wr, 1'b0);
                check("bp_no_rd", in_rd_en, 1'b0);
                @(posedge clk); #1;
            end
            i_full   = 1'b0;
            q_full   = 1'b0;
            in_empty = 1'b1;
            @(negedge clk);
            check("bp_release_i_wr", i_wr, 1'b1);
            check("bp_release_q_wr", q_wr, 1'b1);
            @(posedge clk); #1;
            check("bp_single_write", 64'(writes), 64'(wr_before + 1));
        end

        // Underflow: empty pulses between every byte.
        wr_before = writes;
        for (int g = 0; g < 3; g++) feed_group($urandom, 1);
        repeat (2) @(posedge clk); #1;
        check("underflow_writes", 64'(writes), 64'(wr_before + 3));

        // Reset mid-group discards partial bytes.
        feed(8'hEE, 0);
        feed(8'hDD, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        feed_group(32'h00020001, 0);
        @(negedge clk);
        check("post_reset_wr", i_wr, 1'b1);
        check("post_reset_i", i_din, 32'h00000400);
        check("post_reset_q", q_din, 32'h00000800);
        @(posedge clk); #1;

        // Randomised bytes, gaps and backpressure.
        rnd_full = 1'b1;
        for (int g = 0; g < 40; g++) feed_group($urandom, $urandom_range(2));
        rnd_full = 1'b0;
        i_full   = 1'b0;
        q_full   = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("drain_pending", pending, 1'b0);

`ifdef IQ_DEINT_COUNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_period = 1'b1;
        for (int g = 0; g < 1000; g++) feed_group($urandom, 0);
        chk_period = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("count_1000", sample_count, 32'd1000);
        force dut.cnt_q = 32'hFFFFFFFF;
        model_count = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.cnt_q;
        feed_group($urandom, 0);
        repeat (2) @(posedge clk); #1;
        check("count_wrap", sample_count, 32'd0);
`endif

        check("total_writes", 64'(writes), 64'(exp_writes));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iq_deinterleave.md
Name: iq_deinterleave

Overview:
Front-end producer for the complex FIR stage. It reads a raw interleaved byte stream from an upstream FIFO. Each 4-byte group (I_lo, I_hi, Q_lo, Q_hi) becomes one signed 16-bit I sample and one signed 16-bit Q sample. Each sample is sign-extended, quantized by a left shift and written to the real (I) and imaginary (Q) sample FIFOs. The two writes happen in lock-step, and these FIFOs feed the complex FIR's I/Q inputs.

Parameters:
DATA_SIZE, 32, width of each output sample word
BITS, 10, quantization left-shift applied to each 16-bit sample; DATA_SIZE >= 16+BITS is required (elaboration-time check)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset
in_empty  input  1  upstream byte FIFO empty (first-word-fall-through)
in_rd_en  output  1  pop strobe to upstream byte FIFO
in_dout  input  8  current head byte of upstream FIFO
i_out_full  input  1  I-sample FIFO full
i_out_wr_en  output  1  I-sample FIFO write strobe
i_out_din  output  DATA_SIZE  quantized I sample
q_out_full  input  1  Q-sample FIFO full
q_out_wr_en  output  1  Q-sample FIFO write strobe
q_out_din  output  DATA_SIZE  quantized Q sample

Interface facts (decided): single clock `clock`. Port `reset` is asynchronous and active-low.

Behaviour:
- Reset (reset=0, async):
  - state=S_READ, byte_cnt=0.
  - Byte holding regs = 0.
  - i_out_din = q_out_din = 0, i_out_wr_en = q_out_wr_en = 0.
  - in_rd_en forced 0 while reset=0.
- Reset asserted mid-group or mid-write: any partial bytes and any pending sample pair are discarded. No write is issued.
- S_READ:
  - in_rd_en = !in_empty (combinational).
  - When in_rd_en=1, in_dout is captured into byte slot byte_cnt and byte_cnt increments.
  - On capturing slot 3, byte_cnt wraps to 0 and the state moves to S_WRITE.
  - in_empty=1 holds state and byte_cnt; no bubble penalty beyond the stall itself.
- Sample formation (registered on the slot-3 capture):
  - I16 = {slot1,slot0}, Q16 = {slot3,slot2}, both little-endian and signed two's complement.
  - Output word = sign_extend(X16, DATA_SIZE) << BITS, truncated to DATA_SIZE.
- S_WRITE:
  - i_out_wr_en = q_out_wr_en = !i_out_full && !q_out_full (combinational, identical).
  - Both writes occur in the same cycle or neither does. Partial writes are never issued.
  - On the write, the state returns to S_READ. in_rd_en=0 throughout S_WRITE.
- Latency: the write strobe is asserted in the cycle after the 4th byte is popped, provided neither output FIFO is full.
- Throughput: 1 I/Q pair per 5 cycles, unstalled.
- Backpressure: the block stays in S_WRITE with din stable until both fulls are 0. No upstream bytes are consumed while waiting.
- Simultaneous events:
  - A full flag deasserting in the same cycle S_WRITE is entered: the write occurs that cycle.
  - in_empty toggling during S_WRITE has no effect.
- Output din values are held between writes; they change only on the slot-3 capture.

Optional Feature:
IQ_DEINT_COUNT_EN
- Defined:
  - Adds output port sample_count [31:0]: a count of I/Q pairs written.
  - Reset to 0; increments by 1 on each cycle with i_out_wr_en=1.
  - Wraps from 0xFFFFFFFF to 0. Registered (visible the cycle after the write).
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bytes 0x34,0x12,0xCD,0xAB, outputs never full -> one write with i_out_din=0x0048D000 and q_out_din=0xFEAF3400, one cycle after the 4th pop.
- Extremes: bytes 0x00,0x80,0xFF,0x7F -> i_out_din=0xFE000000 (I16=0x8000), q_out_din=0x01FFFC00 (I16... Q16=0x7FFF).
- Backpressure:
  - i_out_full=1 for 10 cycles after a group -> no wr_en and in_rd_en=0 for 10 cycles; a single paired write follows on the first cycle the full clears.
  - Repeat with only q_out_full=1 -> same result; no lone I write.
- Underflow: in_empty pulsed high between every byte of 3 consecutive groups -> exactly 3 paired writes with correct values, and byte order is preserved.
- Reset mid-group: pop 2 bytes, pulse reset low, then feed 0x01,0x00,0x02,0x00 -> first write is I=0x00000400, Q=0x00000800; the partial bytes are discarded.
- With IQ_DEINT_COUNT_EN: stream 1000 groups unstalled -> sample_count=1000, paired writes every 5 cycles. Force the counter to 0xFFFFFFFF, write one pair -> sample_count=0.
